// File: rtl/dkong_sound_latch.sv
// dkong_sound_latch: main-board sound command latches with SACK handshake tracking
module dkong_sound_latch #(
  parameter int TIMEOUT = 24000
) (
  input  logic       W_CLK_24M,
  input  logic       I_RST,
  input  logic [2:0] I_CPU_A,
  input  logic [7:0] I_CPU_D,
  input  logic       I_3D_WE,
  input  logic       I_6H_WE,
  input  logic       I_5H_WE,
  input  logic       I_4H_WE,
  input  logic       I_SACK,
  output logic [4:0] O_3D_Q,
  output logic [6:0] O_6H_Q,
  output logic       O_5H_Q0,
  output logic [1:0] O_4H_Q,
  output logic       O_BUSY,
  output logic       O_TIMEOUT,
  output logic       O_OVERRUN
);
  typedef enum logic [1:0] {IDLE, DATA, WAIT_ACK} state_t;
  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
  state_t state, state_n;
  logic [15:0] timer, timer_n;
  logic timeout_n, overrun_n;
  logic sack_1, sack_2, sack_3;
  logic ack, arm;
  logic unused;
  assign unused = ^I_CPU_D[7:5];
  assign ack = sack_2 & ~sack_3;
  assign arm = I_5H_WE & I_CPU_D[0];
  assign O_BUSY = state != IDLE;
  // SACK crosses into the 24 MHz domain through two flops, the third detects its rising edge
  always_ff @(posedge W_CLK_24M or posedge I_RST)
    if (I_RST) {sack_1, sack_2, sack_3} <= '0;
    else {sack_1, sack_2, sack_3} <= {I_SACK, sack_1, sack_2};
  // CPU-visible latches update regardless of handshake state
  always_ff @(posedge W_CLK_24M or posedge I_RST)
    if (I_RST) begin
      O_3D_Q  <= '0;
      O_6H_Q  <= '0;
      O_5H_Q0 <= 1'b0;
      O_4H_Q  <= '0;
    end else begin
      if (I_3D_WE) O_3D_Q <= I_CPU_D[4:0];
      if (I_6H_WE && I_CPU_A != 3'd7) O_6H_Q[I_CPU_A] <= I_CPU_D[0];
      if (I_5H_WE) O_5H_Q0 <= I_CPU_D[0];
      if (I_4H_WE && I_CPU_A[2:1] == 2'd0) O_4H_Q[I_CPU_A[0]] <= I_CPU_D[0];
    end
  // handshake state, ack timer and sticky status flags
  always_ff @(posedge W_CLK_24M or posedge I_RST)
    if (I_RST) begin
      state     <= IDLE;
      timer     <= '0;
      O_TIMEOUT <= 1'b0;
      O_OVERRUN <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      O_TIMEOUT <= timeout_n;
      O_OVERRUN <= overrun_n;
    end
  // next state: ack beats timeout, timeout beats a re-arm, a data rewrite freezes the timer
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    timeout_n = O_TIMEOUT;
    overrun_n = O_OVERRUN;
    if (state == IDLE) begin
      if (I_3D_WE) begin
        state_n   = DATA;
        timeout_n = 1'b0;
        overrun_n = 1'b0;
      end
    end else if (state == DATA) begin
      if (arm) begin
        state_n = WAIT_ACK;
        timer_n = '0;
      end
    end else begin
      overrun_n = O_OVERRUN | I_3D_WE;
      if (ack) state_n = IDLE;
      else if (timer == LAST) begin
        state_n   = IDLE;
        timeout_n = 1'b1;
      end else if (arm) timer_n = '0;
      else if (!I_3D_WE) timer_n = (timer == 16'hFFFF) ? timer : timer + 16'd1;
    end
  end
endmodule

// File: tb/tb_dkong_sound_latch.sv
// tb_dkong_sound_latch: randomized scoreboard bench against a behavioural model
module tb_dkong_sound_latch;
  localparam int TO = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] a = '0;
  logic [7:0] d = '0;
  logic we3 = 0, we6 = 0, we5 = 0, we4 = 0, sack = 0;
  logic [4:0] q3;
  logic [6:0] q6;
  logic q5;
  logic [1:0] q4;
  logic busy, tmo, ovr;
  int checks = 0, errors = 0;
  logic [17:0] expq[$];
  logic [4:0] m3;
  logic [6:0] m6;
  logic m5;
  logic [1:0] m4;
  int mst, mtim;
  logic mto, mov;
  logic [3:1] hist;
  wire [17:0] obs = {q3, q6, q5, q4, busy, tmo, ovr};

  always #5 clk = ~clk;

  dkong_sound_latch #(.TIMEOUT(TO)) dut (
    .W_CLK_24M(clk), .I_RST(rst), .I_CPU_A(a), .I_CPU_D(d),
    .I_3D_WE(we3), .I_6H_WE(we6), .I_5H_WE(we5), .I_4H_WE(we4), .I_SACK(sack),
    .O_3D_Q(q3), .O_6H_Q(q6), .O_5H_Q0(q5), .O_4H_Q(q4),
    .O_BUSY(busy), .O_TIMEOUT(tmo), .O_OVERRUN(ovr)
  );

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [17:0] model_vec();
    return {m3, m6, m5, m4, mst != 0, mto, mov};
  endfunction

  task automatic model_reset();
    m3 = 0; m6 = 0; m5 = 0; m4 = 0; mst = 0; mtim = 0; mto = 0; mov = 0; hist = 0;
  endtask

  // mst: 0 idle, 1 data loaded, 2 waiting for ack; ack is SACK seen high two edges ago but low three edges ago
  task automatic model_step();
    logic ackm;
    ackm = hist[2] && !hist[3];
    hist = {hist[2], hist[1], sack};
    if (mst == 0) begin
      if (we3) begin mst = 1; mto = 0; mov = 0; end
    end else if (mst == 1) begin
      if (we5 && d[0]) begin mst = 2; mtim = 0; end
    end else begin
      if (we3) mov = 1;
      if (ackm) mst = 0;
      else if (mtim == TO - 1) begin mst = 0; mto = 1; end
      else if (we5 && d[0]) mtim = 0;
      else if (!we3 && mtim < 65535) mtim = mtim + 1;
    end
    if (we3) m3 = d[4:0];
    if (we6 && a != 3'd7) m6[a] = d[0];
    if (we5) m5 = d[0];
    if (we4 && a[2:1] == 2'd0) m4[a[0]] = d[0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    expq.push_back(model_vec());
    @(negedge clk);
    {we3, we6, we5, we4} = '0;
  endtask

  task automatic wr(input int which, input logic [2:0] aa, input logic [7:0] dd);
    a = aa; d = dd;
    we3 = which == 3; we6 = which == 6; we5 = which == 5; we4 = which == 4;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    chk("async_reset", obs, 18'd0);
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    logic [17:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("scoreboard", obs, e);
      end
    end
  end

  initial begin
    model_reset();
    #1 chk("reset_state", obs, 18'd0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    wr(3, 0, 8'h1A);
    chk("3d_load", {13'd0, q3}, 18'h1A);
    chk("busy_data", {17'd0, busy}, 18'd1);
    wr(5, 0, 8'h01);
    sack = 1;
    idle(2);
    chk("busy_before_ack", {17'd0, busy}, 18'd1);
    idle(1);
    chk("ack_3clk", {16'd0, busy, tmo}, 18'd0);
    sack = 0;
    idle(3);
    wr(3, 0, 8'h11);
    wr(5, 0, 8'h01);
    idle(TO - 1);
    chk("busy_pre_timeout", {17'd0, busy}, 18'd1);
    idle(1);
    chk("timeout", {16'd0, busy, tmo}, 18'd1);
    wr(3, 0, 8'h02);
    chk("timeout_clear", {17'd0, tmo}, 18'd0);
    wr(5, 0, 8'h01);
    wr(3, 0, 8'h05);
    chk("overrun", {q3, q6, q5, q4, busy, tmo, ovr} & 18'h3E007, {5'h05, 13'h0005});
    sack = 1;
    idle(3);
    chk("overrun_sticky", {16'd0, busy, ovr}, 18'd1);
    sack = 0;
    idle(3);
    wr(6, 3, 8'h01);
    wr(6, 7, 8'h01);
    chk("6h_bits", {11'd0, q6}, 18'h08);
    wr(4, 1, 8'h01);
    chk("4h_bit1", {16'd0, q4}, 18'd2);
    wr(4, 2, 8'h01);
    chk("4h_ignored", {16'd0, q4}, 18'd2);
    wr(3, 0, 8'h03);
    wr(5, 0, 8'h01);
    idle(5);
    sack = 1;
    idle(3);
    chk("collision", {16'd0, busy, tmo}, 18'd0);
    sack = 0;
    idle(3);
    wr(3, 0, 8'h1F);
    wr(5, 0, 8'h01);
    idle(2);
    sack = 1;
    do_reset();
    idle(6);
    sack = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) sack = ~sack;
      a = 3'($urandom);
      d = 8'($urandom);
      we3 = $urandom_range(0, 7) == 0;
      we6 = $urandom_range(0, 5) == 0;
      we5 = $urandom_range(0, 5) == 0;
      we4 = $urandom_range(0, 5) == 0;
      tick();
      if (i == 1500) do_reset();
    end
    idle(2);
    chk("queue_drained", 18'(expq.size()), 18'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
